// File: rtl/ecc_result_serializer.sv
// ecc_result_serializer: captures the affine result point (Rx, Ry) on the
// multiplier's completion pulse and streams it out as WORD_WIDTH-bit beats over
// a valid/ready interface: all Rx words, then all Ry words. A result that
// arrives while a previous one is still held or draining is dropped and raises
// the sticky overflow flag.
//
// Build option: define ECC_SER_MSW_FIRST_EN to emit each coordinate
// most-significant word first. When it is undefined, words go out
// least-significant first.
module ecc_result_serializer #(
  parameter int unsigned DATA_WIDTH = 192,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] Rx,
  input  logic [DATA_WIDTH-1:0] Ry,
  input  logic                  in_valid,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overflow,
  input  logic                  clr_ovf
);

  localparam int unsigned NUM_WORDS = DATA_WIDTH / WORD_WIDTH;
  localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StSendX, StSendY} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] ry_q, ry_d;
  logic [WORD_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  overflow_q, overflow_d;

  logic                  hs;
  logic [IDX_W-1:0]      phys_idx;
  logic [DATA_WIDTH-1:0] sel_coord;

  // Next-state logic: FSM, operand capture, overflow, and the next output beat.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rx_d       = rx_q;
    ry_d       = ry_q;
    overflow_d = overflow_q;
    hs         = out_valid_q && out_ready;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          rx_d    = Rx;
          ry_d    = Ry;
          idx_d   = '0;
          state_d = StSendX;
        end
      end
      StSendX: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = StSendY;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StSendY: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A drop outranks a clear that lands in the same cycle.
    if (in_valid && busy_q) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end

`ifdef ECC_SER_MSW_FIRST_EN
    phys_idx = LAST_IDX - idx_d;
`else
    phys_idx = idx_d;
`endif

    // Outputs are computed from the next state so they can be registered
    // without adding a cycle of latency.
    sel_coord   = (state_d == StSendY) ? ry_d : rx_d;
    out_valid_d = (state_d != StIdle);
    busy_d      = (state_d != StIdle);
    out_last_d  = (state_d == StSendY) && (idx_d == LAST_IDX);
    out_data_d  = out_valid_d ? sel_coord[phys_idx * WORD_WIDTH +: WORD_WIDTH] : '0;
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ecc_result_serializer.sv
// Bench for ecc_result_serializer: table-driven basic stream, hand-written
// backpressure / overflow / mid-stream-reset sequences, then random traffic
// checked against a queue-based reference model.
module tb_ecc_result_serializer;

  localparam int DW = 192;
  localparam int WW = 32;
  localparam int NW = DW / WW;
  localparam int NB = 2 * NW;
`ifdef ECC_SER_MSW_FIRST_EN
  localparam bit MSW = 1'b1;
`else
  localparam bit MSW = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, out_ready, clr_ovf;
  logic [DW-1:0] rx, ry;
  logic [WW-1:0] out_data;
  logic          out_valid, out_last, busy, overflow;

  ecc_result_serializer #(
    .DATA_WIDTH(DW),
    .WORD_WIDTH(WW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Rx       (rx),
    .Ry       (ry),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  typedef struct packed {
    logic [WW-1:0] w;
    logic          l;
  } beat_t;

  typedef struct {
    logic          iv;
    logic          v;
    logic [WW-1:0] d;
    logic          l;
    logic          b;
  } vec_t;

  beat_t         mq[$];   // beats the model still expects, front = current
  logic          m_ovf;
  logic [WW-1:0] got[$];  // words actually accepted in a sequence
  vec_t          tbl[NB+1];
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] word_of(input logic [DW-1:0] c, input int i);
    return c[i*WW +: WW];
  endfunction

  // Reference model: a result becomes a list of 12 beats; handshakes pop it.
  task automatic model_edge();
    bit    was_busy;
    beat_t b;
    int    i;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      was_busy = (mq.size() != 0);
      if (in_valid && was_busy) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      if (was_busy && out_ready) begin
        void'(mq.pop_front());
      end else if (!was_busy && in_valid) begin
        for (int c = 0; c < 2; c++) begin
          for (int j = 0; j < NW; j++) begin
            i   = MSW ? (NW - 1 - j) : j;
            b.w = word_of((c == 0) ? rx : ry, i);
            b.l = (c == 1) && (j == NW - 1);
            mq.push_back(b);
          end
        end
      end
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".valid"}, out_valid, mq.size() != 0);
    chk({tag, ".busy"}, busy, mq.size() != 0);
    chk({tag, ".ovf"}, overflow, m_ovf);
    if (mq.size() != 0) begin
      chk({tag, ".data"}, out_data, mq[0].w);
      chk({tag, ".last"}, out_last, mq[0].l);
    end else begin
      chk({tag, ".last"}, out_last, 1'b0);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare #1 later.
  task automatic step(input logic iv, input logic rdy, input logic clr, input logic r,
                      input string tag);
    in_valid  = iv;
    out_ready = rdy;
    clr_ovf   = clr;
    rst       = r;
    if (out_valid && rdy && !r) got.push_back(out_data);
    @(posedge clk);
    model_edge();
    #1;
    model_check(tag);
  endtask

  // Run until idle; mode 1 gives ready pattern 1,0,0,1,0,0,...
  task automatic drain(input int mode, input string tag);
    int cyc = 0;
    while (busy && cyc < 200) begin
      step(1'b0, (mode == 0) ? 1'b1 : (cyc % 3 == 0), 1'b0, 1'b0, tag);
      cyc++;
    end
    if (busy) chk({tag, ".timeout"}, busy, 1'b0);
  endtask

  task automatic check_basic_words(input string tag);
    chk({tag, ".count"}, got.size(), NB);
    for (int k = 0; k < NB && k < got.size(); k++) chk({tag, ".word"}, got[k], tbl[k].d);
  endtask

  task automatic load_basic();
    for (int i = 0; i < NW; i++) begin
      rx[i*WW +: WW] = WW'(i + 1);
      ry[i*WW +: WW] = WW'(32'hA0 + i);
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < NW; i++) begin
      rx[i*WW +: WW] = $urandom;
      ry[i*WW +: WW] = $urandom;
    end
  endtask

  initial begin
    int j;
    int i;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
    rx = '0; ry = '0;
    mq.delete();
    m_ovf = 1'b0;

    // Basic-stream table: row k is the state after edge k (in_valid at row 0).
    for (int k = 0; k <= NB; k++) begin
      tbl[k].iv = (k == 0);
      tbl[k].v  = (k < NB);
      tbl[k].b  = (k < NB);
      tbl[k].l  = (k == NB - 1);
      j = k % NW;
      i = MSW ? (NW - 1 - j) : j;
      tbl[k].d = (k >= NB) ? '0 : (k < NW) ? WW'(i + 1) : WW'(32'hA0 + i);
    end

    // Reset held two cycles with out_ready high.
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, "reset");
      chk("reset.data", out_data, '0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, "idle");

    // Basic stream from the table.
    load_basic();
    for (int k = 0; k <= NB; k++) begin
      in_valid  = tbl[k].iv;
      out_ready = 1'b1;
      @(posedge clk);
      model_edge();
      #1;
      chk("basic.valid", out_valid, tbl[k].v);
      chk("basic.busy", busy, tbl[k].b);
      chk("basic.last", out_last, tbl[k].l);
      if (tbl[k].v) chk("basic.data", out_data, tbl[k].d);
    end

    // Backpressure: ready 1,0,0,1,...
    got.delete();
    step(1'b1, 1'b0, 1'b0, 1'b0, "bp.start");
    drain(1, "bp");
    check_basic_words("bp");

    // Overflow: second pulse at beat 4 with different data.
    got.delete();
    step(1'b1, 1'b1, 1'b0, 1'b0, "ovf.start");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0, "ovf.run");
    rx = ~rx;
    ry = ~ry;
    step(1'b1, 1'b1, 1'b0, 1'b0, "ovf.drop");
    drain(0, "ovf");
    check_basic_words("ovf");
    chk("ovf.sticky", overflow, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, "ovf.clr");
    chk("ovf.cleared", overflow, 1'b0);

    // Reset mid-stream, then a fresh complete result.
    load_basic();
    step(1'b1, 1'b1, 1'b0, 1'b0, "mrst.start");
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'b0, 1'b0, "mrst.run");
    step(1'b0, 1'b1, 1'b0, 1'b1, "mrst.rst");
    chk("mrst.valid", out_valid, 1'b0);
    chk("mrst.busy", busy, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, "mrst.idle");
    chk("mrst.novalid", out_valid, 1'b0);
    got.delete();
    step(1'b1, 1'b1, 1'b0, 1'b0, "mrst.new");
    drain(0, "mrst.drain");
    check_basic_words("mrst");

    // Random traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      load_random();
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
